// File: rtl/clock_ctrl.sv
// Board clock timekeeper: hh:mm:ss in packed BCD with a RUN / SET_HOURS / SET_MINS
// set-mode FSM, debounced MODE/INC buttons and a blink mask for the field being set.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// RUN        | time advances on each 1 Hz strobe, INC ignored
// SET_HOURS  | seconds frozen, INC advances hours (23 -> 00), hours blink
// SET_MINS   | seconds frozen, INC advances minutes (59 -> 00), minutes blink
module clock_ctrl #(
    parameter int          DEBOUNCE_N  = 3,
    parameter int          BLINK_DIV   = 60,
    parameter logic [7:0]  RESET_HOURS = 8'h12
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_pulse_f,
    input  logic       i_pulse_n,
    input  logic       i_btn_mode,
    input  logic       i_btn_inc,
    output logic [7:0] o_hours,
    output logic [7:0] o_mins,
    output logic [7:0] o_secs,
    output logic [1:0] o_mode,
    output logic       o_blank_h,
    output logic       o_blank_m
);

    localparam logic [1:0] MODE_RUN    = 2'b00;
    localparam logic [1:0] MODE_SET_H  = 2'b01;
    localparam logic [1:0] MODE_SET_M  = 2'b10;
    localparam int         BW          = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [1:0]    mode_sync, inc_sync;
    logic          mode_db, inc_db;
    logic [3:0]    mode_cnt, inc_cnt;
    logic          mode_press, inc_press;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    logic          mode_db_n, inc_db_n;
    logic [3:0]    mode_cnt_n, inc_cnt_n;
    logic [7:0]    hours_n, mins_n, secs_n;
    logic [1:0]    mode_n;
    logic [BW-1:0] blink_cnt_n;
    logic          blink_phase_n;
    logic          tick;

    // Counter holds N-1 at most: the Nth differing sample flips the level instead.
    function automatic logic [4:0] db_step(input logic strobe, input logic sample,
                                           input logic level, input logic [3:0] cnt);
        logic       level_n;
        logic [3:0] cnt_n;
        level_n = level;
        cnt_n   = cnt;
        if (strobe) begin
            if (sample == level) begin
                cnt_n = 4'd0;
            end else if (cnt == 4'(DEBOUNCE_N - 1)) begin
                level_n = ~level;
                cnt_n   = 4'd0;
            end else begin
                cnt_n = cnt + 4'd1;
            end
        end
        return {level_n, cnt_n};
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v == max_v) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    always_comb begin
        {mode_db_n, mode_cnt_n} = db_step(i_pulse_f, mode_sync[1], mode_db, mode_cnt);
        {inc_db_n, inc_cnt_n}   = db_step(i_pulse_f, inc_sync[1], inc_db, inc_cnt);
    end

    always_comb begin
        hours_n       = o_hours;
        mins_n        = o_mins;
        secs_n        = o_secs;
        mode_n        = o_mode;
        blink_cnt_n   = blink_cnt;
        blink_phase_n = blink_phase;
        tick          = i_pulse_n && (o_mode == MODE_RUN);

        if (tick) begin
            secs_n = bcd_inc(o_secs, 8'h59);
            if (o_secs == 8'h59) begin
                mins_n = bcd_inc(o_mins, 8'h59);
                if (o_mins == 8'h59) begin
                    hours_n = bcd_inc(o_hours, 8'h23);
                end
            end
        end

        // MODE has priority over INC when both press events land together.
        case (o_mode)
            MODE_RUN: begin
                if (mode_press) begin
                    mode_n = MODE_SET_H;
                end
            end
            MODE_SET_H: begin
                if (mode_press) begin
                    mode_n = MODE_SET_M;
                end else if (inc_press) begin
                    hours_n = bcd_inc(o_hours, 8'h23);
                end
            end
            MODE_SET_M: begin
                if (mode_press) begin
                    mode_n = MODE_RUN;
                    secs_n = 8'h00;
                end else if (inc_press) begin
                    mins_n = bcd_inc(o_mins, 8'h59);
                end
            end
            default: begin
                mode_n = MODE_RUN;
            end
        endcase

        if ((o_mode != MODE_RUN) && i_pulse_f) begin
            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt_n   = '0;
                blink_phase_n = ~blink_phase;
            end else begin
                blink_cnt_n = blink_cnt + BW'(1);
            end
        end

        // Entering a set field restarts the blink so the field starts visible.
        if ((mode_n != o_mode) && (mode_n != MODE_RUN)) begin
            blink_cnt_n   = '0;
            blink_phase_n = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mode_sync   <= 2'b00;
            inc_sync    <= 2'b00;
            mode_db     <= 1'b0;
            inc_db      <= 1'b0;
            mode_cnt    <= 4'd0;
            inc_cnt     <= 4'd0;
            mode_press  <= 1'b0;
            inc_press   <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            o_hours     <= RESET_HOURS;
            o_mins      <= 8'h00;
            o_secs      <= 8'h00;
            o_mode      <= MODE_RUN;
            o_blank_h   <= 1'b0;
            o_blank_m   <= 1'b0;
        end else begin
            mode_sync   <= {mode_sync[0], i_btn_mode};
            inc_sync    <= {inc_sync[0], i_btn_inc};
            mode_db     <= mode_db_n;
            inc_db      <= inc_db_n;
            mode_cnt    <= mode_cnt_n;
            inc_cnt     <= inc_cnt_n;
            mode_press  <= mode_db_n & ~mode_db;
            inc_press   <= inc_db_n & ~inc_db;
            blink_cnt   <= blink_cnt_n;
            blink_phase <= blink_phase_n;
            o_hours     <= hours_n;
            o_mins      <= mins_n;
            o_secs      <= secs_n;
            o_mode      <= mode_n;
            o_blank_h   <= (mode_n == MODE_SET_H) & blink_phase_n;
            o_blank_m   <= (mode_n == MODE_SET_M) & blink_phase_n;
        end
    end

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl: a decimal reference model predicts every output
// snapshot, which is queued on drive and popped for comparison once outputs settle.
module tb_clock_ctrl;

    localparam int DEB  = 3;
    localparam int BDIV = 60;

    logic       clk = 1'b0;
    logic       rst, pf, pn, btn_m, btn_i;
    logic [7:0] o_hours, o_mins, o_secs;
    logic [1:0] o_mode;
    logic       o_blank_h, o_blank_m;

    always #5 clk = ~clk;

    clock_ctrl #(
        .DEBOUNCE_N (DEB),
        .BLINK_DIV  (BDIV),
        .RESET_HOURS(8'h12)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_pulse_f (pf),
        .i_pulse_n (pn),
        .i_btn_mode(btn_m),
        .i_btn_inc (btn_i),
        .o_hours   (o_hours),
        .o_mins    (o_mins),
        .o_secs    (o_secs),
        .o_mode    (o_mode),
        .o_blank_h (o_blank_h),
        .o_blank_m (o_blank_m)
    );

    typedef struct packed {
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        logic [1:0] md;
        logic       bh;
        logic       bm;
    } snap_t;

    snap_t exp_q[$];
    string tag_q[$];
    int    checks   = 0;
    int    failures = 0;

    // reference model state, plain decimal
    int hh, mm, ss, md, bcnt, ph;

    function automatic logic [7:0] bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic model_reset();
        hh = 12; mm = 0; ss = 0; md = 0; bcnt = 0; ph = 0;
    endtask

    task automatic model_advance();
        ss++;
        if (ss == 60) begin
            ss = 0;
            mm++;
            if (mm == 60) begin
                mm = 0;
                hh = (hh + 1) % 24;
            end
        end
    endtask

    task automatic model_blink();
        if (md != 0) begin
            if (bcnt == BDIV - 1) begin
                bcnt = 0;
                ph   = ph ^ 1;
            end else begin
                bcnt++;
            end
        end
    endtask

    task automatic model_press(input bit pm, input bit pi, input bit tk);
        if (tk && md == 0) model_advance();
        if (pm) begin
            case (md)
                0: begin md = 1; bcnt = 0; ph = 0; end
                1: begin md = 2; bcnt = 0; ph = 0; end
                default: begin md = 0; ss = 0; end
            endcase
        end else if (pi) begin
            if (md == 1) hh = (hh + 1) % 24;
            else if (md == 2) mm = (mm + 1) % 60;
        end
    endtask

    task automatic push_exp(input string tag);
        snap_t e;
        e.h  = bcd(hh);
        e.m  = bcd(mm);
        e.s  = bcd(ss);
        e.md = 2'(md);
        e.bh = (md == 1) && (ph == 1);
        e.bm = (md == 2) && (ph == 1);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_out();
        snap_t e;
        string t;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty: got no queued expectation, required one");
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            assert (o_hours === e.h) else begin
                failures++;
                $error("FAIL %s hours: got %h required %h", t, o_hours, e.h);
            end
            checks++;
            assert (o_mins === e.m) else begin
                failures++;
                $error("FAIL %s mins: got %h required %h", t, o_mins, e.m);
            end
            checks++;
            assert (o_secs === e.s) else begin
                failures++;
                $error("FAIL %s secs: got %h required %h", t, o_secs, e.s);
            end
            checks++;
            assert (o_mode === e.md) else begin
                failures++;
                $error("FAIL %s mode: got %b required %b", t, o_mode, e.md);
            end
            checks++;
            assert (o_blank_h === e.bh) else begin
                failures++;
                $error("FAIL %s blank_h: got %b required %b", t, o_blank_h, e.bh);
            end
            checks++;
            assert (o_blank_m === e.bm) else begin
                failures++;
                $error("FAIL %s blank_m: got %b required %b", t, o_blank_m, e.bm);
            end
        end
    endtask

    task automatic expect_now(input string tag);
        push_exp(tag);
        check_out();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        pn = 1'b1;
        step();
        pn = 1'b0;
        if (md == 0) model_advance();
    endtask

    task automatic strobe();
        pf = 1'b1;
        model_blink();
        step();
        pf = 1'b0;
        repeat (3) step();
    endtask

    // Hold the button(s) for 'hold' fast strobes; optionally land a 1 Hz tick on
    // the exact cycle the press event is acted upon.
    task automatic press(input bit pm, input bit pi, input int hold, input bit tick_with);
        btn_m = pm;
        btn_i = pi;
        repeat (3) step();
        for (int i = 1; i <= hold; i++) begin
            pf = 1'b1;
            model_blink();
            step();
            pf = 1'b0;
            if (i == DEB) begin
                if (tick_with) begin
                    pn = 1'b1;
                    step();
                    pn = 1'b0;
                end
                model_press(pm, pi, tick_with);
            end
            repeat (3) step();
        end
        btn_m = 1'b0;
        btn_i = 1'b0;
        repeat (3) step();
        repeat (DEB) strobe();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        step();
    endtask

    initial begin
        rst   = 1'b1;
        pf    = 1'b0;
        pn    = 1'b0;
        btn_m = 1'b0;
        btn_i = 1'b0;
        model_reset();
        repeat (3) step();
        expect_now("reset");
        rst = 1'b0;
        step();

        repeat (3) tick();
        expect_now("run_3ticks");

        press(1'b1, 1'b0, DEB - 1, 1'b0);
        expect_now("mode_short_hold");
        press(1'b1, 1'b0, DEB + 3, 1'b0);
        expect_now("mode_held_once");

        repeat (12) press(1'b0, 1'b1, DEB, 1'b0);
        expect_now("hours_wrap");
        press(1'b1, 1'b0, DEB, 1'b0);
        expect_now("to_set_mins");
        repeat (59) press(1'b0, 1'b1, DEB, 1'b0);
        expect_now("mins_59");
        press(1'b0, 1'b1, DEB, 1'b0);
        expect_now("mins_wrap_no_carry");
        press(1'b1, 1'b0, DEB, 1'b1);
        expect_now("to_run_secs_clear_tick_drop");

        press(1'b1, 1'b0, DEB, 1'b0);
        repeat (23) press(1'b0, 1'b1, DEB, 1'b0);
        press(1'b1, 1'b0, DEB, 1'b0);
        repeat (59) press(1'b0, 1'b1, DEB, 1'b0);
        press(1'b1, 1'b0, DEB, 1'b0);
        expect_now("set_23_59");
        repeat (59) tick();
        expect_now("at_23_59_59");
        tick();
        expect_now("midnight_wrap");
        repeat (599) tick();
        expect_now("at_00_09_59");
        tick();
        expect_now("carry_00_10_00");

        press(1'b1, 1'b0, DEB, 1'b1);
        expect_now("run_to_set_h_tick_applied");
        repeat (BDIV - 4) begin
            strobe();
            tick();
        end
        expect_now("blink_before_wrap");
        strobe();
        expect_now("blink_phase_on");
        repeat (3) begin
            strobe();
            tick();
        end
        expect_now("secs_frozen");

        press(1'b1, 1'b1, DEB, 1'b0);
        expect_now("mode_beats_inc");

        repeat (5) strobe();
        do_reset();
        expect_now("reset_mid_blink");
        rst = 1'b0;
        tick();
        expect_now("run_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
